pshift_frame_ctrl: RTL and testbench
====================================

// Module: pshift_frame_ctrl
// PURPOSE
//  Upstream sequencer for the parallel-in/serial-out shift register in the outlying circuitry.
//  - Accepts parallel words over a valid/ready handshake.
//  - Drives the register's data/load pins, tracks the WIDTH serial bit times and emits a one-cycle latch strobe.
//  - Inserts a programmable idle gap between frames (LED / indicator driver chains).
// PARAMETERS
//  WIDTH  16  bits per frame; must equal the downstream shift register width; >= 2
//  GAP    2   idle cycles after latch before next word accepted; >= 0
// PORTS
//  clk           in   1      system clock; all state updates on rising edge
//  rst_n         in   1      reset, asynchronous assert, active-low
//  in_data       in   WIDTH  word to serialise, MSB sent first
//  in_valid      in   1      in_data valid
//  in_ready      out  1      controller can accept a word (registered)
//  sr_data       out  WIDTH  parallel data to the shift register
//  sr_load       out  1      shift register load strobe, one cycle per frame
//  frame_active  out  1      high exactly while a frame bit is on the shift register's serial out
//  latch         out  1      one-cycle strobe after last bit (downstream storage latch)
//  busy          out  1      high in every state except IDLE
// BEHAVIOUR
//  - One clock; reset asynchronous, active-low.
//  - Reset values: state IDLE; in_ready, sr_load, frame_active, latch and busy all 0; sr_data 0; counters 0.
//  - in_ready rises on the first clk edge after rst_n deasserts.
//  - FSM: IDLE -> LOAD -> SHIFT -> LATCH -> GAP -> IDLE. GAP is skipped when GAP==0 (LATCH -> IDLE).
//  - IDLE: in_ready=1. On an edge with in_valid&&in_ready: capture in_data into the hold register, go to LOAD.
//    in_ready drops in the same edge.
//  - LOAD: one cycle, sr_load=1, sr_data=hold register. Then SHIFT with bit counter=0.
//  - SHIFT: WIDTH cycles, frame_active=1, counter increments each cycle.
//    In SHIFT cycle k, serial out carries hold[WIDTH-1-k]. Leave when counter==WIDTH-1.
//  - LATCH: one cycle, latch=1. Then GAP (gap counter=0), or IDLE if GAP==0.
//  - GAP: GAP cycles, all strobes 0; leave when gap counter==GAP-1.
//  - sr_data holds the captured word from LOAD until the next capture; it is never driven from in_data directly.
//  - Latency: handshake at edge t -> sr_load high in cycle t+1 -> MSB on serial out in cycle t+2
//    -> latch in cycle t+2+WIDTH -> in_ready high again in cycle t+3+WIDTH+GAP.
//  - Throughput: one word per WIDTH+GAP+3 cycles, including the IDLE accept cycle.
//  - in_valid while not ready: ignored, no capture. in_data may change freely outside the handshake edge.
//  - Back-to-back requests: in_valid held high across a frame is accepted only on the first IDLE cycle.
//  - Reset mid-frame: immediate return to IDLE values.
//    The shift register keeps stale bits; frame_active=0 marks them invalid. No latch is issued for an aborted frame.
//  - The shift register fills with zeros after the frame, so serial out is 0 from cycle t+2+WIDTH until the next load.
//  - Counter widths: bit counter $clog2(WIDTH); gap counter $clog2(GAP+1), minimum 1 bit.
//    Counters never wrap: they are reset on state entry.
//  - All outputs registered or decoded from the state register only; no path from in_valid to any output.
// STRUCTURE
//  - Shared package/header: FSM state encoding localparams (IDLE, LOAD, SHIFT, LATCH, GAP, 3-bit) and a clog2 helper.
//    Also used by other outlying-circuitry sequencers.
//  - No sub-module required. The FSM, bit counter, gap counter and hold register live in one always block
//    plus output decode.
//  - Bench instantiates this block driving a WIDTH-matched shift register to check the serial stream end to end.
// TESTING
//  1. Reset release, in_valid=0 -> all outputs 0 during reset; in_ready=1 one edge after rst_n rises; no strobes.
//  2. WIDTH=16, GAP=2, word 16'hA5C3 -> sr_load 1 cycle; serial out 1010_0101_1100_0011 over exactly 16 frame_active cycles;
//     latch at cycle t+18; in_ready back at t+21.
//  3. in_valid held high with words 16'hFFFF then 16'h0001 -> second word accepted only after the gap.
//     Serial stream shows 16 ones, then zeros, then 15 zeros and a one.
//  4. in_data changed every cycle after the handshake -> serialised word equals the value at the handshake edge.
//  5. rst_n pulled low at SHIFT cycle 7 -> outputs zero asynchronously, no latch; next word after release serialises cleanly.
//  6. GAP=0, WIDTH=2, word 2'b10 -> LATCH->IDLE direct; frames repeat every 5 cycles with in_valid held high.

Source files
------------

// File: rtl/pshift_frame_ctrl_pkg.sv
// Shared definitions for the outlying-circuitry serial sequencers.
// Provides the FSM state encoding and a width helper for counters.
package pshift_frame_ctrl_pkg;

    // 3-bit state encoding shared by every sequencer built on this package.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_LATCH = 3'd3,
        ST_GAP   = 3'd4
    } pshift_state_e;

    // Ceiling log2 of v, never less than 1 so a counter always has a bit.
    function automatic int clog2_min1(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < v) begin
                r = r + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/pshift_frame_ctrl.sv
// Frame sequencer for a downstream parallel-in/serial-out shift register:
// accepts a word over valid/ready, loads it, counts WIDTH bit times,
// pulses a latch strobe and then waits GAP idle cycles.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   in_data/in_valid   word to serialise (MSB first) and its valid
//   in_ready           registered ready, high only in IDLE
//   sr_data/sr_load    parallel data and load strobe to the register
//   frame_active       high while a frame bit is on the serial out
//   latch              one-cycle strobe after the last bit
//   busy               high in every state except IDLE
module pshift_frame_ctrl
    import pshift_frame_ctrl_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int GAP   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] sr_data,
    output logic             sr_load,
    output logic             frame_active,
    output logic             latch,
    output logic             busy
);

    localparam int BCW = clog2_min1(WIDTH);
    localparam int GCW = clog2_min1(GAP + 1);

    localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);
    // With GAP==0 the GAP state is never entered; the value is unused.
    localparam logic [GCW-1:0] GAP_LAST = GCW'((GAP > 0) ? GAP - 1 : 0);

    pshift_state_e    state_q, state_d;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [GCW-1:0]   gap_cnt_q, gap_cnt_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             rdy_q, rdy_d;
    logic             accept;

    // Handshake only against the registered ready.
    assign accept = in_valid && rdy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            hold_q    <= '0;
            rdy_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            hold_q    <= hold_d;
            rdy_q     <= rdy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        hold_d    = hold_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    hold_d  = in_data;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                bit_cnt_d = '0;
                state_d   = ST_SHIFT;
            end
            ST_SHIFT: begin
                // Stop on the last bit instead of incrementing so the
                // counter never wraps when WIDTH is a power of two.
                if (bit_cnt_q == BIT_LAST) begin
                    state_d = ST_LATCH;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            ST_LATCH: begin
                if (GAP == 0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = '0;
                    state_d   = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Ready is registered one edge ahead so it is high exactly in IDLE,
        // except the first cycle out of reset.
        rdy_d = (state_d == ST_IDLE);
    end

    assign in_ready     = rdy_q;
    assign sr_data      = hold_q;
    assign sr_load      = (state_q == ST_LOAD);
    assign frame_active = (state_q == ST_SHIFT);
    assign latch        = (state_q == ST_LATCH);
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pshift_frame_ctrl.sv
// Directed bench: two controller instances, each driving a model of the
// downstream shift register, with the serial stream checked end to end.
module tb_pshift_frame_ctrl;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vec;
    int miss;

    // Instance A: WIDTH=16, GAP=2
    logic        rst_a_n;
    logic [15:0] in_data_a;
    logic        in_valid_a;
    logic        in_ready_a;
    logic [15:0] sr_data_a;
    logic        sr_load_a;
    logic        fa_a;
    logic        latch_a;
    logic        busy_a;
    logic [15:0] sreg_a = '0;
    logic        sout_a;

    // Instance B: WIDTH=2, GAP=0
    logic        rst_b_n;
    logic [1:0]  in_data_b;
    logic        in_valid_b;
    logic        in_ready_b;
    logic [1:0]  sr_data_b;
    logic        sr_load_b;
    logic        fa_b;
    logic        latch_b;
    logic        busy_b;
    logic [1:0]  sreg_b = '0;
    logic        sout_b;

    pshift_frame_ctrl #(.WIDTH(16), .GAP(2)) u_a (
        .clk          (clk),
        .rst_n        (rst_a_n),
        .in_data      (in_data_a),
        .in_valid     (in_valid_a),
        .in_ready     (in_ready_a),
        .sr_data      (sr_data_a),
        .sr_load      (sr_load_a),
        .frame_active (fa_a),
        .latch        (latch_a),
        .busy         (busy_a)
    );

    pshift_frame_ctrl #(.WIDTH(2), .GAP(0)) u_b (
        .clk          (clk),
        .rst_n        (rst_b_n),
        .in_data      (in_data_b),
        .in_valid     (in_valid_b),
        .in_ready     (in_ready_b),
        .sr_data      (sr_data_b),
        .sr_load      (sr_load_b),
        .frame_active (fa_b),
        .latch        (latch_b),
        .busy         (busy_b)
    );

    // Downstream shift registers: parallel load, shift left, zero fill.
    always @(posedge clk) begin
        if (sr_load_a) sreg_a <= sr_data_a;
        else           sreg_a <= {sreg_a[14:0], 1'b0};
        if (sr_load_b) sreg_b <= sr_data_b;
        else           sreg_b <= {sreg_b[0], 1'b0};
    end
    assign sout_a = sreg_a[15];
    assign sout_b = sreg_b[1];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Outputs and inputs both change 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered one tick after the handshake edge (LOAD cycle).
    // Follows the frame through latch and gap and ends back in IDLE.
    task automatic frame_a(input logic [15:0] w, input bit keep_valid,
                           input bit scramble, input string tag);
        logic [15:0] got;
        int          n;
        if (!keep_valid) in_valid_a = 1'b0;
        if (scramble) in_data_a = 16'($urandom);
        chk({tag, " load"}, {28'd0, sr_load_a, in_ready_a, busy_a, fa_a},
            32'h0000_000A);
        chk({tag, " sr_data"}, {16'd0, sr_data_a}, {16'd0, w});
        got = '0;
        n = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (scramble) in_data_a = 16'($urandom);
            if (fa_a === 1'b1) n++;
            got = {got[14:0], sout_a};
        end
        chk({tag, " serial"}, {16'd0, got}, {16'd0, w});
        chk({tag, " active_cnt"}, 32'(n), 32'd16);
        tick();
        chk({tag, " latch"}, {29'd0, latch_a, fa_a, sout_a}, 32'h4);
        for (int g = 0; g < 2; g++) begin
            tick();
            chk({tag, " gap"},
                {27'd0, latch_a, sr_load_a, in_ready_a, busy_a, sout_a},
                32'h2);
        end
        tick();
        chk({tag, " idle"}, {30'd0, in_ready_a, busy_a}, 32'h2);
        chk({tag, " sr_hold"}, {16'd0, sr_data_a}, {16'd0, w});
    endtask

    logic [31:0] ld_v, fa_v, lt_v, rd_v, so_v, bz_v;
    logic        saw_latch;

    initial begin
        vec = 0;
        miss = 0;
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        in_data_a = '0;
        in_valid_a = 1'b0;
        in_data_b = 2'b10;
        in_valid_b = 1'b1;

        // 1: reset and release
        tick();
        tick();
        chk("rst_a outs",
            {27'd0, in_ready_a, sr_load_a, fa_a, latch_a, busy_a}, 32'h0);
        chk("rst_a sr_data", {16'd0, sr_data_a}, 32'h0);
        chk("rst_b outs",
            {27'd0, in_ready_b, sr_load_b, fa_b, latch_b, busy_b}, 32'h0);
        rst_a_n = 1'b1;
        #1;
        chk("rel ready0", {31'd0, in_ready_a}, 32'h0);
        tick();
        chk("rel ready1",
            {27'd0, in_ready_a, sr_load_a, fa_a, latch_a, busy_a}, 32'h10);

        // 2: single frame A5C3
        in_data_a = 16'hA5C3;
        in_valid_a = 1'b1;
        tick();
        frame_a(16'hA5C3, 1'b0, 1'b0, "t2");

        // 3: valid held high, FFFF then 0001
        in_data_a = 16'hFFFF;
        in_valid_a = 1'b1;
        tick();
        in_data_a = 16'h0001;
        frame_a(16'hFFFF, 1'b1, 1'b0, "t3a");
        tick();
        frame_a(16'h0001, 1'b0, 1'b0, "t3b");

        // 4: in_data scrambled after the handshake
        in_data_a = 16'h3C5A;
        in_valid_a = 1'b1;
        tick();
        frame_a(16'h3C5A, 1'b0, 1'b1, "t4");

        // 5: reset asserted in SHIFT cycle 7
        in_data_a = 16'h1234;
        in_valid_a = 1'b1;
        tick();
        in_valid_a = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        chk("t5 pre", {30'd0, fa_a, sout_a}, {30'd0, 1'b1, 1'b0});
        rst_a_n = 1'b0;
        #1;
        chk("t5 async",
            {27'd0, in_ready_a, sr_load_a, fa_a, latch_a, busy_a}, 32'h0);
        chk("t5 sr_data", {16'd0, sr_data_a}, 32'h0);
        saw_latch = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (latch_a !== 1'b0 || fa_a !== 1'b0) saw_latch = 1'b1;
        end
        chk("t5 no_latch", {31'd0, saw_latch}, 32'h0);
        in_data_a = 16'hBEEF;
        in_valid_a = 1'b1;
        rst_a_n = 1'b1;
        #1;
        tick();
        chk("t5 no_capture", {30'd0, in_ready_a, busy_a}, 32'h2);
        tick();
        frame_a(16'hBEEF, 1'b0, 1'b0, "t5");

        // 6: WIDTH=2 GAP=0, valid held, 5-cycle cadence
        rst_b_n = 1'b1;
        #1;
        ld_v = '0; fa_v = '0; lt_v = '0; rd_v = '0; so_v = '0; bz_v = '0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            ld_v[i] = sr_load_b;
            fa_v[i] = fa_b;
            lt_v[i] = latch_b;
            rd_v[i] = in_ready_b;
            so_v[i] = sout_b;
            bz_v[i] = busy_b;
        end
        chk("t6 load", ld_v, 32'h0000_1084);
        chk("t6 active", fa_v, 32'h0000_6318);
        chk("t6 latch", lt_v, 32'h0000_8420);
        chk("t6 ready", rd_v, 32'h0001_0842);
        chk("t6 serial", so_v, 32'h0000_2108);
        chk("t6 busy", bz_v, 32'h0000_F7BC);
        chk("t6 sr_data", {30'd0, sr_data_b}, 32'h2);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
